// File: rtl/jpeg_pkg.sv
// Shared definitions for the JPEG back-end stages.
//   rle_sched_state_e : block scheduler FSM states
//   COMP_Y/CB/CR      : 2-bit component IDs carried on tid
//   BLOCK_LEN, BEAT_W : 8x8 block length in beats and beat counter width
package jpeg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_Y    = 3'd1,
    ST_CB   = 3'd2,
    ST_CR   = 3'd3,
    ST_DONE = 3'd4
  } rle_sched_state_e;

  localparam logic [1:0] COMP_Y  = 2'd0;
  localparam logic [1:0] COMP_CB = 2'd1;
  localparam logic [1:0] COMP_CR = 2'd2;

  localparam int BLOCK_LEN = 64;
  localparam int BEAT_W    = 6;

endpackage

// File: rtl/rle_sched_mux.sv
// 3:1 AXI-Stream mux with one-hot select and ready steering.
// Ports:
//   sel        : one-hot select, bit 0 = Y, bit 1 = Cb, bit 2 = Cr; all-zero
//                selects nothing (valid and data forced to 0)
//   y/cb/cr_tdata, in_tvalid, in_tlast : source side, packed {cr,cb,y}
//   in_tready  : per-source ready, only the selected one follows out_tready
//   out_tdata, out_tvalid : selected stream toward the sink
//   out_tlast_src : tlast of the selected source (not forwarded as framing)
//   out_tready : sink ready
module rle_sched_mux #(
  parameter int DATA_WIDTH = 12
) (
  input  logic [2:0]                   sel,
  input  logic signed [DATA_WIDTH-1:0] y_tdata,
  input  logic signed [DATA_WIDTH-1:0] cb_tdata,
  input  logic signed [DATA_WIDTH-1:0] cr_tdata,
  input  logic [2:0]                   in_tvalid,
  input  logic [2:0]                   in_tlast,
  output logic [2:0]                   in_tready,
  output logic signed [DATA_WIDTH-1:0] out_tdata,
  output logic                         out_tvalid,
  output logic                         out_tlast_src,
  input  logic                         out_tready
);

  always_comb begin
    out_tdata     = '0;
    out_tvalid    = 1'b0;
    out_tlast_src = 1'b0;
    if (sel[0]) begin
      out_tdata     = y_tdata;
      out_tvalid    = in_tvalid[0];
      out_tlast_src = in_tlast[0];
    end else if (sel[1]) begin
      out_tdata     = cb_tdata;
      out_tvalid    = in_tvalid[1];
      out_tlast_src = in_tlast[1];
    end else if (sel[2]) begin
      out_tdata     = cr_tdata;
      out_tvalid    = in_tvalid[2];
      out_tlast_src = in_tlast[2];
    end
  end

  assign in_tready = sel & {3{out_tready}};

endmodule

// File: rtl/rle_block_sched.sv
// Block scheduler in front of the rle stage. Interleaves Y, Cb and Cr
// coefficient streams in MCU order (Y_PER_MCU Y blocks, one Cb, one Cr),
// framing each block as exactly 64 beats. Runs mcu_count_i MCUs per start_i.
// Ports:
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   start_i, mcu_count_i : frame start (IDLE only) and MCU count to latch
//   busy_o, frame_done_o : frame in progress / one-cycle end-of-frame pulse
//   s_axis_{y,cb,cr}_*   : component coefficient streams, zigzag order
//   m_axis_*             : merged stream; tlast = beat 63, tuser = beat 0
//                          (DC), tid = component
//   err_o                : sticky source-tlast framing error
// Build option: define RLE_SCHED_LAST_CHECK_EN to compare each accepted
// source tlast against the block position and flag mismatches on err_o.
// Without it err_o is tied to 0. Source tlast never affects sequencing.
module rle_block_sched
  import jpeg_pkg::*;
#(
  parameter int DATA_WIDTH    = 12,
  parameter int Y_PER_MCU     = 4,
  parameter int MCU_CNT_WIDTH = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  input  logic [MCU_CNT_WIDTH-1:0]     mcu_count_i,
  output logic                         busy_o,
  output logic                         frame_done_o,
  input  logic signed [DATA_WIDTH-1:0] s_axis_y_tdata,
  input  logic                         s_axis_y_tvalid,
  output logic                         s_axis_y_tready,
  input  logic                         s_axis_y_tlast,
  input  logic signed [DATA_WIDTH-1:0] s_axis_cb_tdata,
  input  logic                         s_axis_cb_tvalid,
  output logic                         s_axis_cb_tready,
  input  logic                         s_axis_cb_tlast,
  input  logic signed [DATA_WIDTH-1:0] s_axis_cr_tdata,
  input  logic                         s_axis_cr_tvalid,
  output logic                         s_axis_cr_tready,
  input  logic                         s_axis_cr_tlast,
  output logic signed [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic [1:0]                   m_axis_tid,
  output logic                         m_axis_tuser,
  output logic                         err_o
);

  localparam logic [1:0]        Y_LAST    = 2'(Y_PER_MCU - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BLOCK_LEN - 1);

  rle_sched_state_e         state_q, state_d;
  logic [BEAT_W-1:0]        beat_q;
  logic [1:0]               yblk_q;
  logic [MCU_CNT_WIDTH-1:0] mcu_q, count_q;

  logic       active, hs, beat_last, start_ok, mcu_more, sel_last;
  logic [2:0] sel, rdy;

  assign active    = (state_q == ST_Y) || (state_q == ST_CB) || (state_q == ST_CR);
  assign sel       = {state_q == ST_CR, state_q == ST_CB, state_q == ST_Y};
  assign hs        = m_axis_tvalid && m_axis_tready;
  assign beat_last = (beat_q == BEAT_LAST);
  assign start_ok  = (state_q == ST_IDLE) && start_i;
  // One extra bit so mcu_q + 1 cannot wrap at the top of the counter range.
  assign mcu_more  = ({1'b0, mcu_q} + (MCU_CNT_WIDTH+1)'(1)) < {1'b0, count_q};

  rle_sched_mux #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mux (
    .sel          (sel),
    .y_tdata      (s_axis_y_tdata),
    .cb_tdata     (s_axis_cb_tdata),
    .cr_tdata     (s_axis_cr_tdata),
    .in_tvalid    ({s_axis_cr_tvalid, s_axis_cb_tvalid, s_axis_y_tvalid}),
    .in_tlast     ({s_axis_cr_tlast, s_axis_cb_tlast, s_axis_y_tlast}),
    .in_tready    (rdy),
    .out_tdata    (m_axis_tdata),
    .out_tvalid   (m_axis_tvalid),
    .out_tlast_src(sel_last),
    .out_tready   (m_axis_tready)
  );

  assign {s_axis_cr_tready, s_axis_cb_tready, s_axis_y_tready} = rdy;

  // Framing is derived from the beat counter only, gated outside a frame.
  assign m_axis_tlast = active && beat_last;
  assign m_axis_tuser = active && (beat_q == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    busy_o       = 1'b0;
    frame_done_o = 1'b0;
    m_axis_tid   = COMP_Y;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = (mcu_count_i == '0) ? ST_DONE : ST_Y;
        end
      end
      ST_Y: begin
        busy_o     = 1'b1;
        m_axis_tid = COMP_Y;
        if (hs && beat_last && (yblk_q == Y_LAST)) state_d = ST_CB;
      end
      ST_CB: begin
        busy_o     = 1'b1;
        m_axis_tid = COMP_CB;
        if (hs && beat_last) state_d = ST_CR;
      end
      ST_CR: begin
        busy_o     = 1'b1;
        m_axis_tid = COMP_CR;
        if (hs && beat_last) state_d = mcu_more ? ST_Y : ST_DONE;
      end
      ST_DONE: begin
        busy_o       = 1'b1;
        frame_done_o = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_q  <= '0;
      yblk_q  <= '0;
      mcu_q   <= '0;
      count_q <= '0;
    end else if (start_ok) begin
      count_q <= mcu_count_i;
      beat_q  <= '0;
      yblk_q  <= '0;
      mcu_q   <= '0;
    end else if (hs) begin
      beat_q <= beat_q + 1'b1;
      if (beat_last) begin
        if (state_q == ST_Y) yblk_q <= (yblk_q == Y_LAST) ? 2'd0 : yblk_q + 2'd1;
        if (state_q == ST_CR) mcu_q <= mcu_q + 1'b1;
      end
    end
  end

`ifdef RLE_SCHED_LAST_CHECK_EN
  logic err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (start_ok) begin
      err_q <= 1'b0;
    end else if (hs && (sel_last != beat_last)) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  logic unused_sel_last;
  assign unused_sel_last = sel_last;
  assign err_o           = 1'b0;
`endif

endmodule

// File: tb/tb_rle_block_sched.sv
// Randomized bench for rle_block_sched with a frame-level reference model:
// the expected component of every beat follows from its index in the frame,
// and expected data comes from per-component scoreboards of what each source
// offered.
module tb_rle_block_sched;
  import jpeg_pkg::*;

  localparam int DW    = 12;
  localparam int YPM   = 4;
  localparam int CW    = 16;
  localparam int NB    = YPM + 2;
  localparam int DEPTH = 4096;
`ifdef RLE_SCHED_LAST_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] mcu_count = '0;
  logic          busy, frame_done, err;
  logic [DW-1:0] y_d, cb_d, cr_d, m_d;
  logic          y_r, cb_r, cr_r;
  logic          m_v, m_l, m_u;
  logic [1:0]    m_id;

  // Source/sink drive state.
  logic [DW-1:0] src_mem [3][DEPTH];
  int            src_idx [3] = '{0, 0, 0};
  logic [2:0]    sv = '0;
  logic [2:0]    sl = '0;
  logic          m_r = 1'b0;
  bit            src_rand = 1'b0, snk_rand = 1'b0, inject = 1'b0;

  // Written by the monitor only.
  logic [2:0] hs_s = '0;
  int         pos [3] = '{0, 0, 0};
  int         checks = 0, failures = 0;
  int         cyc = 0, n_beats = 0, n_tlast = 0, n_done = 0, n_busy = 0, n_vld = 0;
  int         n_tid [3] = '{0, 0, 0};
  int         start_cyc = 0, done_lat = 0;

  typedef enum {M_IDLE, M_RUN, M_DONE} mph_e;
  mph_e mph = M_IDLE;
  int   mn = 0, mtotal = 0;
  int   eidx [3] = '{0, 0, 0};
  bit   merr = 1'b0;

  always #5 clk = ~clk;

  assign y_d  = src_mem[0][src_idx[0] % DEPTH];
  assign cb_d = src_mem[1][src_idx[1] % DEPTH];
  assign cr_d = src_mem[2][src_idx[2] % DEPTH];

  rle_block_sched #(
    .DATA_WIDTH(DW), .Y_PER_MCU(YPM), .MCU_CNT_WIDTH(CW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start), .mcu_count_i(mcu_count),
    .busy_o(busy), .frame_done_o(frame_done),
    .s_axis_y_tdata(y_d), .s_axis_y_tvalid(sv[0]), .s_axis_y_tready(y_r), .s_axis_y_tlast(sl[0]),
    .s_axis_cb_tdata(cb_d), .s_axis_cb_tvalid(sv[1]), .s_axis_cb_tready(cb_r), .s_axis_cb_tlast(sl[1]),
    .s_axis_cr_tdata(cr_d), .s_axis_cr_tvalid(sv[2]), .s_axis_cr_tready(cr_r), .s_axis_cr_tlast(sl[2]),
    .m_axis_tdata(m_d), .m_axis_tvalid(m_v), .m_axis_tready(m_r), .m_axis_tlast(m_l),
    .m_axis_tid(m_id), .m_axis_tuser(m_u), .err_o(err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Component of frame beat n: blocks cycle Y x YPM, Cb, Cr.
  function automatic int comp_of(input int n);
    int b;
    b = (n / BLOCK_LEN) % NB;
    return (b < YPM) ? 0 : b - YPM + 1;
  endfunction

  // Sources and sink: hold a beat until accepted, then move to the next one.
  always @(posedge clk) begin
    #1;
    for (int c = 0; c < 3; c++) begin
      if (hs_s[c]) begin
        src_idx[c]++;
        sv[c] = src_rand ? 1'($urandom_range(1, 0)) : 1'b1;
      end else if (!sv[c]) begin
        sv[c] = src_rand ? 1'($urandom_range(1, 0)) : 1'b1;
      end
      sl[c] = (pos[c] == 63) || (inject && c == 1 && pos[c] == 62);
    end
    m_r = snk_rand ? 1'($urandom_range(1, 0)) : 1'b1;
  end

  // Reference model and per-cycle comparison.
  always @(negedge clk) begin
    int         comp;
    logic       ev;
    logic [2:0] erdy;
    hs_s = {sv[2] && cr_r, sv[1] && cb_r, sv[0] && y_r};
    cyc++;
    if (!rst_ni) begin
      mph  = M_IDLE;
      merr = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_done", frame_done, 0);
      chk("rst_tvalid", m_v, 0);
      chk("rst_ready", {cr_r, cb_r, y_r}, 0);
      chk("rst_tuser", m_u, 0);
      chk("rst_err", err, 0);
    end else begin
      case (mph)
        M_IDLE: begin
          chk("idle_busy", busy, 0);
          chk("idle_done", frame_done, 0);
          chk("idle_tvalid", m_v, 0);
          chk("idle_ready", {cr_r, cb_r, y_r}, 0);
          chk("idle_tuser", m_u, 0);
          chk("idle_err", err, merr);
          if (start) begin
            for (int c = 0; c < 3; c++) pos[c] = 0;
            merr      = 1'b0;
            start_cyc = cyc;
            if (mcu_count == '0) begin
              mph = M_DONE;
            end else begin
              mph    = M_RUN;
              mn     = 0;
              mtotal = int'(mcu_count) * NB * BLOCK_LEN;
            end
          end
        end
        M_RUN: begin
          comp = comp_of(mn);
          ev   = sv[comp];
          erdy = m_r ? 3'(1 << comp) : 3'b000;
          chk("run_tvalid", m_v, ev);
          chk("run_ready", {cr_r, cb_r, y_r}, erdy);
          chk("run_busy", busy, 1);
          chk("run_done", frame_done, 0);
          chk("run_tid", m_id, comp);
          chk("run_tuser", m_u, (mn % BLOCK_LEN) == 0);
          chk("run_tlast", m_l, (mn % BLOCK_LEN) == BLOCK_LEN - 1);
          chk("run_err", err, merr);
          if (ev) chk("run_tdata", m_d, src_mem[comp][eidx[comp] % DEPTH]);
          if (ev && m_r) begin
            if (sl[comp] != ((mn % BLOCK_LEN) == BLOCK_LEN - 1)) merr = merr | CHK;
            eidx[comp]++;
            mn++;
            if (mn == mtotal) mph = M_DONE;
          end
        end
        default: begin
          chk("done_tvalid", m_v, 0);
          chk("done_ready", {cr_r, cb_r, y_r}, 0);
          chk("done_busy", busy, 1);
          chk("done_pulse", frame_done, 1);
          chk("done_tuser", m_u, 0);
          chk("done_err", err, merr);
          mph = M_IDLE;
        end
      endcase
    end
    for (int c = 0; c < 3; c++) if (hs_s[c]) pos[c] = (pos[c] + 1) % BLOCK_LEN;
    if (m_v && m_r) begin
      n_beats++;
      n_tid[m_id]++;
      if (m_l) n_tlast++;
    end
    if (m_v) n_vld++;
    if (busy) n_busy++;
    if (frame_done) begin
      n_done++;
      done_lat = cyc - start_cyc;
    end
  end

  task automatic pulse_start(input int cnt);
    @(posedge clk); #1;
    mcu_count = CW'(cnt);
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < limit && !seen; k++) begin
      @(negedge clk);
      if (frame_done) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL frame_done_timeout: got none expected pulse within %0d cycles", limit);
    end
    @(posedge clk);
  endtask

  int b_beats, b_tid0, b_tid1, b_tid2, b_tlast, b_done, b_busy, b_vld;

  task automatic snap();
    @(posedge clk);
    b_beats = n_beats; b_tid0 = n_tid[0]; b_tid1 = n_tid[1]; b_tid2 = n_tid[2];
    b_tlast = n_tlast; b_done = n_done; b_busy = n_busy; b_vld = n_vld;
  endtask

  initial begin
    bit hit;
    for (int c = 0; c < 3; c++)
      for (int i = 0; i < DEPTH; i++) src_mem[c][i] = DW'($urandom);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy_lit", busy, 0);
    chk("reset_tvalid_lit", m_v, 0);
    @(posedge clk); #1;
    rst_ni = 1'b1;

    // One 4:2:0 MCU, no back-pressure: 384 beats back to back.
    snap();
    pulse_start(1);
    wait_done(1000);
    chk("t1_beats", n_beats - b_beats, 384);
    chk("t1_tid_y", n_tid[0] - b_tid0, 256);
    chk("t1_tid_cb", n_tid[1] - b_tid1, 64);
    chk("t1_tid_cr", n_tid[2] - b_tid2, 64);
    chk("t1_tlast", n_tlast - b_tlast, 6);
    chk("t1_done_lat", done_lat, 385);
    chk("t1_done_cnt", n_done - b_done, 1);

    // Empty frame.
    snap();
    pulse_start(0);
    wait_done(10);
    chk("t2_vld", n_vld - b_vld, 0);
    chk("t2_done_lat", done_lat, 1);
    chk("t2_busy_cycles", n_busy - b_busy, 1);

    // Three MCUs with random valid and ready.
    src_rand = 1'b1;
    snk_rand = 1'b1;
    snap();
    pulse_start(3);
    wait_done(20000);
    chk("t3_beats", n_beats - b_beats, 3 * NB * BLOCK_LEN);
    chk("t3_tid_cb", n_tid[1] - b_tid1, 3 * BLOCK_LEN);
    src_rand = 1'b0;
    snk_rand = 1'b0;

    // start_i while busy is ignored, count is not re-latched.
    snap();
    pulse_start(2);
    repeat (200) @(posedge clk);
    pulse_start(5);
    wait_done(3000);
    repeat (400) @(posedge clk);
    chk("t4_beats", n_beats - b_beats, 2 * NB * BLOCK_LEN);
    chk("t4_done_cnt", n_done - b_done, 1);

    // Reset mid-frame, then restart from Y beat 0.
    pulse_start(1);
    hit = 1'b0;
    for (int k = 0; k < 500 && !hit; k++) begin
      @(posedge clk);
      if (mn == 100) hit = 1'b1;
    end
    chk("t5_reached_beat100", hit, 1);
    #1;
    rst_ni = 1'b0;
    @(negedge clk);
    chk("t5_busy_lit", busy, 0);
    chk("t5_tvalid_lit", m_v, 0);
    chk("t5_yready_lit", y_r, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    pulse_start(1);
    @(negedge clk);
    chk("t5_restart_tvalid", m_v, 1);
    chk("t5_restart_tuser", m_u, 1);
    chk("t5_restart_tid", m_id, COMP_Y);
    wait_done(1000);

    // Cb source flags tlast one beat early.
    inject = 1'b1;
    pulse_start(1);
    wait_done(1000);
    chk("t6_err_after", err, CHK);
    inject = 1'b0;
    pulse_start(1);
    @(negedge clk);
    chk("t6_err_cleared", err, 0);
    wait_done(1000);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
